// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states, owner encoding and default widths.
package sram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_WSETUP,
        ST_WSTROBE,
        ST_WHOLD,
        ST_RADDR,
        ST_RSAMPLE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_REC   = 2'd1,
        OWN_PLAY  = 2'd2,
        OWN_CLEAN = 2'd3
    } owner_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational requester selector: rec/play round-robin, clean only when both are quiet.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic       rec_req,
    input  logic       play_req,
    input  logic       clean_req,
    input  logic       last_play,
    input  logic [1:0] mask,
    output logic [1:0] pick
);

    logic rec;
    logic play;
    logic clean;

    // The masked requester has just been granted and its req drop is not visible yet.
    assign rec   = rec_req   && (mask != OWN_REC);
    assign play  = play_req  && (mask != OWN_PLAY);
    assign clean = clean_req && (mask != OWN_CLEAN);

    always_comb begin
        pick = OWN_NONE;
        if (rec && play) begin
            pick = last_play ? OWN_REC : OWN_PLAY;
        end else if (rec) begin
            pick = OWN_REC;
        end else if (play) begin
            pick = OWN_PLAY;
        end else if (clean) begin
            pick = OWN_CLEAN;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-client asynchronous SRAM arbiter (recorder write, playback read, clean write).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_rec_req,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [DATA_W-1:0] i_rec_wdata,
    output logic              o_rec_gnt,
    input  logic              i_play_req,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic              o_play_gnt,
    output logic [DATA_W-1:0] o_play_rdata,
    input  logic              i_clean_req,
    input  logic [ADDR_W-1:0] i_clean_addr,
    input  logic [DATA_W-1:0] i_clean_wdata,
    output logic              o_clean_gnt,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_ce_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n,
    output logic              o_busy,
    output logic [1:0]        o_owner
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC);

    state_t            state;
    state_t            nxt;
    owner_t            own;
    owner_t            retire;
    logic              last_play;
    logic              last_read;
    logic [2:0]        cnt;
    logic              sel;
    logic [1:0]        pick;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    sram_arb_pick u_pick (
        .rec_req   (i_rec_req),
        .play_req  (i_play_req),
        .clean_req (i_clean_req),
        .last_play (last_play),
        .mask      (retire),
        .pick      (pick)
    );

    always_comb begin
        sel_addr  = i_rec_addr;
        sel_wdata = i_rec_wdata;
        if (pick == OWN_PLAY) begin
            sel_addr = i_play_addr;
        end else if (pick == OWN_CLEAN) begin
            sel_addr  = i_clean_addr;
            sel_wdata = i_clean_wdata;
        end
    end

    always_comb begin
        nxt = state;
        sel = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_en && (pick != OWN_NONE)) begin
                    sel = 1'b1;
                    if (pick == OWN_PLAY) begin
                        nxt = ST_RADDR;
                    end else begin
                        nxt = last_read ? ST_TURN : ST_WSETUP;
                    end
                end
            end
            ST_TURN:    nxt = ST_WSETUP;
            ST_WSETUP:  nxt = ST_WSTROBE;
            ST_WSTROBE: if (cnt == WAIT_LAST) nxt = ST_WHOLD;
            ST_WHOLD:   nxt = ST_IDLE;
            ST_RADDR:   if (cnt == WAIT_LAST) nxt = ST_RSAMPLE;
            ST_RSAMPLE: nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

    // Every pad/status output is registered from the next state so it lines up with the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            own          <= OWN_NONE;
            retire       <= OWN_NONE;
            last_play    <= 1'b1;
            last_read    <= 1'b0;
            cnt          <= '0;
            o_sram_addr  <= '0;
            o_sram_dq    <= '0;
            o_play_rdata <= '0;
            o_sram_dq_oe <= 1'b0;
            o_sram_we_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_ce_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
            o_busy       <= 1'b0;
            o_rec_gnt    <= 1'b0;
            o_play_gnt   <= 1'b0;
            o_clean_gnt  <= 1'b0;
        end else begin
            state        <= nxt;
            cnt          <= (nxt != state) ? '0 : cnt + 3'd1;
            o_sram_we_n  <= (nxt != ST_WSTROBE);
            o_sram_oe_n  <= !((nxt == ST_RADDR) || (nxt == ST_RSAMPLE));
            o_sram_dq_oe <= (nxt == ST_WSETUP) || (nxt == ST_WSTROBE) || (nxt == ST_WHOLD);
            o_sram_ce_n  <= (nxt == ST_IDLE);
            o_sram_lb_n  <= (nxt == ST_IDLE);
            o_sram_ub_n  <= (nxt == ST_IDLE);
            o_busy       <= (nxt != ST_IDLE);
            o_rec_gnt    <= (nxt == ST_WHOLD) && (own == OWN_REC);
            o_clean_gnt  <= (nxt == ST_WHOLD) && (own == OWN_CLEAN);
            o_play_gnt   <= (nxt == ST_RSAMPLE);
            retire       <= ((state != ST_IDLE) && (nxt == ST_IDLE)) ? own : OWN_NONE;

            if (sel) begin
                own         <= owner_t'(pick);
                o_sram_addr <= sel_addr;
                last_read   <= (pick == OWN_PLAY);
                if (pick == OWN_PLAY) begin
                    last_play <= 1'b1;
                end else begin
                    o_sram_dq <= sel_wdata;
                    if (pick == OWN_REC) last_play <= 1'b0;
                end
            end else if ((state != ST_IDLE) && (nxt == ST_IDLE)) begin
                own <= OWN_NONE;
            end

            if ((state == ST_RADDR) && (nxt == ST_RSAMPLE)) begin
                o_play_rdata <= i_sram_dq;
            end
        end
    end

    assign o_owner = own;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM model, WAIT_CYC=1.
module tb_sram_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic          rec_req = 1'b0, play_req = 1'b0, clean_req = 1'b0;
    logic [AW-1:0] rec_addr = '0, play_addr = '0, clean_addr = '0;
    logic [DW-1:0] rec_wdata = '0, clean_wdata = '0;
    logic          rec_gnt, play_gnt, clean_gnt;
    logic [DW-1:0] play_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq, sram_rdata;
    logic          sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;
    logic          busy;
    logic [1:0]    owner;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_wdata(rec_wdata), .o_rec_gnt(rec_gnt),
        .i_play_req(play_req), .i_play_addr(play_addr), .o_play_gnt(play_gnt), .o_play_rdata(play_rdata),
        .i_clean_req(clean_req), .i_clean_addr(clean_addr), .i_clean_wdata(clean_wdata), .o_clean_gnt(clean_gnt),
        .o_sram_addr(sram_addr), .o_sram_dq(sram_dq), .o_sram_dq_oe(sram_dq_oe), .i_sram_dq(sram_rdata),
        .o_sram_we_n(sram_we_n), .o_sram_oe_n(sram_oe_n), .o_sram_ce_n(sram_ce_n),
        .o_sram_lb_n(sram_lb_n), .o_sram_ub_n(sram_ub_n), .o_busy(busy), .o_owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    who;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // SRAM model and activity counters, all sampled on the falling edge.
    logic [DW-1:0] mem [256] = '{default: '0};
    int            wr_starts [256] = '{default: 0};
    logic          we_prev = 1'b1;
    int            we_low = 0, dq_oe_cnt = 0, dq_bad = 0, turn_cnt = 0, busy_cnt = 0, gnt_cnt = 0;

    assign sram_rdata = sram_oe_n ? '0 : mem[sram_addr[7:0]];

    always @(negedge clk) begin
        we_prev <= sram_we_n;
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq;
        if (!sram_we_n && we_prev) wr_starts[sram_addr[7:0]] <= wr_starts[sram_addr[7:0]] + 1;
        if (!rst) begin
            if (!sram_we_n) we_low <= we_low + 1;
            if (sram_dq_oe) dq_oe_cnt <= dq_oe_cnt + 1;
            if (sram_dq_oe && sram_dq != rec_wdata && sram_dq != clean_wdata) dq_bad <= dq_bad + 1;
            if (busy && !sram_ce_n && sram_we_n && sram_oe_n && !sram_dq_oe) turn_cnt <= turn_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (rec_gnt || play_gnt || clean_gnt) gnt_cnt <= gnt_cnt + 1;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [1:0] w;
        if (!rst && (rec_gnt || play_gnt || clean_gnt)) begin
            w = rec_gnt ? 2'd1 : (play_gnt ? 2'd2 : 2'd3);
            check("gnt_onehot", 32'(rec_gnt) + 32'(play_gnt) + 32'(clean_gnt), 1);
            if (expq.size() == 0) begin
                check("unexpected_gnt", {30'b0, w}, 0);
            end else begin
                e = expq.pop_front();
                check("gnt_owner", {30'b0, w}, {30'b0, e.who});
                check("gnt_addr", {12'b0, sram_addr}, {12'b0, e.addr});
                if (e.who == 2'd2) check("play_rdata", {16'b0, play_rdata}, {16'b0, e.rdata});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic gnt_of(input int which);
        return (which == 0) ? rec_gnt : ((which == 1) ? play_gnt : clean_gnt);
    endfunction

    // Returns the number of ticks until the gnt appears, or 0 on timeout.
    task automatic wait_gnt(input int which, output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (gnt_of(which)) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int k, n, s0, s1, done;
        repeat (3) tick();
        check("rst_strobes", {sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy, owner}, 9'b1_1111_0000);
        check("rst_addr", {12'b0, sram_addr}, 0);
        check("rst_dq", {16'b0, sram_dq}, 0);
        check("rst_rdata", {16'b0, play_rdata}, 0);
        check("rst_gnts", {rec_gnt, play_gnt, clean_gnt}, 0);
        rst = 1'b0;
        tick();

        // single write
        s0 = we_low; s1 = dq_bad;
        rec_addr = 20'h00010; rec_wdata = 16'hBEEF;
        expq.push_back('{2'd1, 20'h00010, 16'h0});
        rec_req = 1'b1;
        wait_gnt(0, k);
        rec_req = 1'b0;
        check("write_latency", k, 4);
        check("write_we_low_cycles", we_low - s0, 2);
        check("write_dq_value", dq_bad - s1, 0);
        check("write_mem", {16'b0, mem[16]}, 32'hBEEF);
        repeat (2) tick();

        // single read
        s0 = dq_oe_cnt;
        play_addr = 20'h00010;
        expq.push_back('{2'd2, 20'h00010, 16'hBEEF});
        play_req = 1'b1;
        wait_gnt(1, k);
        play_req = 1'b0;
        check("read_latency", k, 3);
        check("read_dq_oe_cycles", dq_oe_cnt - s0, 0);
        repeat (4) tick();
        check("rdata_hold", {16'b0, play_rdata}, 32'hBEEF);

        // contention: rec/play alternate, clean waits until both drop
        rec_addr = 20'h00020; rec_wdata = 16'h1111;
        clean_addr = 20'h00030; clean_wdata = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            expq.push_back('{2'd1, 20'h00020, 16'h0});
            expq.push_back('{2'd2, 20'h00010, 16'hBEEF});
        end
        expq.push_back('{2'd3, 20'h00030, 16'h0});
        s0 = turn_cnt; n = 0; done = 0;
        rec_req = 1'b1; play_req = 1'b1; clean_req = 1'b1;
        for (int i = 0; i < 400 && done == 0; i++) begin
            tick();
            if (rec_gnt || play_gnt) begin
                n++;
                if (n == 6) begin
                    rec_req = 1'b0;
                    play_req = 1'b0;
                end
            end
            if (clean_gnt) begin
                clean_req = 1'b0;
                done = 1;
            end
        end
        check("clean_served", done, 1);
        check("grants_before_clean", n, 6);
        check("turn_cycles", turn_cnt - s0, 4);
        check("contention_rec_mem", {16'b0, mem[32]}, 32'h1111);
        check("contention_clean_mem", {16'b0, mem[48]}, 32'h3333);
        repeat (2) tick();

        // enable low blocks all selections
        s0 = gnt_cnt; s1 = busy_cnt;
        en = 1'b0;
        rec_req = 1'b1; play_req = 1'b1; clean_req = 1'b1;
        repeat (10) tick();
        check("en0_gnts", gnt_cnt - s0, 0);
        check("en0_busy", busy_cnt - s1, 0);

        // reset in the middle of WSTROBE
        play_req = 1'b0; clean_req = 1'b0;
        rec_addr = 20'h00040; rec_wdata = 16'h4444;
        en = 1'b1;
        tick(); tick();
        check("pre_reset_we_n", sram_we_n, 0);
        rst = 1'b1;
        #1;
        check("rst_async", {sram_we_n, sram_dq_oe, sram_ce_n, busy, owner}, 6'b10_1000);
        play_addr = 20'h00010;
        play_req = 1'b1;
        expq.push_back('{2'd1, 20'h00040, 16'h0});
        expq.push_back('{2'd2, 20'h00010, 16'hBEEF});
        tick();
        check("rst_no_gnt", {rec_gnt, play_gnt, clean_gnt}, 0);
        rst = 1'b0;
        wait_gnt(0, k);
        rec_req = 1'b0;
        check("post_reset_rec_latency", k, 4);
        wait_gnt(1, k);
        play_req = 1'b0;
        check("post_reset_play_latency", k, 4);
        repeat (2) tick();

        // late req drop after gnt must not cause a second write
        s0 = gnt_cnt;
        rec_addr = 20'h00050; rec_wdata = 16'h5555;
        expq.push_back('{2'd1, 20'h00050, 16'h0});
        rec_req = 1'b1;
        wait_gnt(0, k);
        check("mask_write_latency_turn", k, 5);
        tick();
        rec_req = 1'b0;
        repeat (10) tick();
        check("mask_single_write", wr_starts[80], 1);
        check("mask_single_gnt", gnt_cnt - s0, 1);
        check("mask_mem", {16'b0, mem[80]}, 32'h5555);

        check("queue_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
